// File: rtl/aes_top_pack.sv
// Shared AES-top sizes and the types used by the Avalon-MM host bridge.
package aes_top_pack;

    localparam int ADDRESS_SIZE       = 8;
    localparam int REG_SIZE           = 32;
    localparam int DEFAULT_MM_TIMEOUT = 256;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DATA = 2'd2,
        RESP      = 2'd3
    } aes_mm_host_state_e;

    typedef struct packed {
        logic                    write;
        logic [ADDRESS_SIZE-1:0] address;
        logic [REG_SIZE-1:0]     writedata;
    } mm_cmd_t;

endpackage

// File: rtl/aes_mm_timeout_ctr.sv
// Read-completion watchdog: counts enabled cycles after a clear and flags the
// last allowed cycle so the host can abandon a read from a dead slave.
module aes_mm_timeout_ctr
    import aes_top_pack::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_MM_TIMEOUT,
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [TO_W-1:0] LAST_COUNT = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] count_reg;

    // Saturates on the last cycle; the host leaves WAIT_DATA there anyway.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && !expire) begin
            count_reg <= count_reg + TO_W'(1);
        end
    end

    assign expire = (count_reg == LAST_COUNT);

endmodule

// File: rtl/aes_mm_host.sv
// Avalon-MM master bridging a command/response stream onto the AES register
// port; one transaction in flight, reads guarded by a completion timeout.
module aes_mm_host
    import aes_top_pack::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_MM_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDRESS_SIZE-1:0] cmd_address,
    input  logic [REG_SIZE-1:0]     cmd_writedata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [REG_SIZE-1:0]     rsp_readdata,
    output logic                    rsp_timeout,
    output logic [ADDRESS_SIZE-1:0] mm_master_address,
    output logic                    mm_master_write,
    output logic [REG_SIZE-1:0]     mm_master_writedata,
    output logic                    mm_master_read,
    input  logic                    mm_master_readdatavalid,
    input  logic [REG_SIZE-1:0]     mm_master_readdata,
    input  logic                    mm_master_waitrequest,
    output logic                    busy,
    output logic                    stray_rdv
);

    aes_mm_host_state_e state_reg, state_next;

    mm_cmd_t             cmd_reg, cmd_next;
    logic                write_reg, write_next;
    logic                read_reg, read_next;
    logic                rsp_valid_reg, rsp_valid_next;
    logic [REG_SIZE-1:0] rsp_data_reg, rsp_data_next;
    logic                rsp_timeout_reg, rsp_timeout_next;
    logic                stray_reg, stray_next;

    logic to_clear;
    logic to_enable;
    logic to_expire;

    aes_mm_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (to_clear),
        .enable(to_enable),
        .expire(to_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            cmd_reg         <= '0;
            write_reg       <= 1'b0;
            read_reg        <= 1'b0;
            rsp_valid_reg   <= 1'b0;
            rsp_data_reg    <= '0;
            rsp_timeout_reg <= 1'b0;
            stray_reg       <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cmd_reg         <= cmd_next;
            write_reg       <= write_next;
            read_reg        <= read_next;
            rsp_valid_reg   <= rsp_valid_next;
            rsp_data_reg    <= rsp_data_next;
            rsp_timeout_reg <= rsp_timeout_next;
            stray_reg       <= stray_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (cmd_valid) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (!mm_master_waitrequest) begin
                    state_next = cmd_reg.write ? IDLE : WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (mm_master_readdatavalid || to_expire) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cmd_next         = cmd_reg;
        write_next       = write_reg;
        read_next        = read_reg;
        rsp_valid_next   = rsp_valid_reg;
        rsp_data_next    = rsp_data_reg;
        rsp_timeout_next = rsp_timeout_reg;
        to_clear         = 1'b0;
        to_enable        = 1'b0;
        // Data arriving in any state but WAIT_DATA is discarded but remembered.
        stray_next       = stray_reg
                         | (mm_master_readdatavalid && (state_reg != WAIT_DATA));

        case (state_reg)
            IDLE: begin
                if (cmd_valid) begin
                    cmd_next.write     = cmd_write;
                    cmd_next.address   = cmd_address;
                    cmd_next.writedata = cmd_writedata;
                    write_next         = cmd_write;
                    read_next          = !cmd_write;
                end
            end
            ISSUE: begin
                if (!mm_master_waitrequest) begin
                    write_next = 1'b0;
                    read_next  = 1'b0;
                    to_clear   = !cmd_reg.write;
                end
            end
            WAIT_DATA: begin
                // Real data on the final window cycle beats the timeout.
                if (mm_master_readdatavalid) begin
                    rsp_valid_next   = 1'b1;
                    rsp_data_next    = mm_master_readdata;
                    rsp_timeout_next = 1'b0;
                end else if (to_expire) begin
                    rsp_valid_next   = 1'b1;
                    rsp_data_next    = '0;
                    rsp_timeout_next = 1'b1;
                end else begin
                    to_enable = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_next = 1'b0;
                end
            end
            default: ;
        endcase

        cmd_ready = (state_reg == IDLE);
        busy      = (state_reg != IDLE);
    end

    assign mm_master_address   = cmd_reg.address;
    assign mm_master_writedata = cmd_reg.writedata;
    assign mm_master_write     = write_reg;
    assign mm_master_read      = read_reg;
    assign rsp_valid           = rsp_valid_reg;
    assign rsp_readdata        = rsp_data_reg;
    assign rsp_timeout         = rsp_timeout_reg;
    assign stray_rdv           = stray_reg;

endmodule
